// File: rtl/hex_pager.sv
// rtl/hex_pager.sv - paged 7-segment hex viewer with debounced step key and auto scroll
module hex_pager #(
    parameter int DATA_W     = 128,
    parameter int DIGITS     = 8,
    parameter int DWELL      = 50000000,
    parameter int DEB_CYCLES = 500000,
    parameter int BLANK_CYC  = 2500000,
    localparam int PAGES     = DATA_W / (4 * DIGITS),
    localparam int PW        = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                  CLOCK_50,
    input  logic                  Reset,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_valid,
    input  logic                  hold,
    input  logic                  step_n,
    input  logic                  auto_mode,
    output logic [7*DIGITS-1:0]   hex_seg,
    output logic [PW-1:0]         page_idx,
    output logic                  blank
);

    localparam int DBW = $clog2(DEB_CYCLES + 1);
    localparam int DWW = $clog2(DWELL);
    localparam int BKW = $clog2(BLANK_CYC + 1);

    typedef enum logic [1:0] {S_MANUAL, S_AUTO, S_BLANK} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       page_q, page_d;
    logic [DWW-1:0]      dwell_q, dwell_d;
    logic [BKW-1:0]      blank_cnt_q, blank_cnt_d;
    logic [DATA_W-1:0]   snap_q;
    logic                sync1_q, sync2_q, deb_q;
    logic [DBW-1:0]      deb_cnt_q;
    logic                step_pulse;
    logic                advance;
    logic [DATA_W-1:0]   page_bits;
    logic [7*DIGITS-1:0] seg_d, seg_q;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    // Pulse fires on the same cycle the debounced level falls; releases never pulse.
    assign step_pulse = deb_q && !sync2_q && (deb_cnt_q == DBW'(DEB_CYCLES - 1));

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= step_n;
            sync2_q <= sync1_q;
            if (sync2_q == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DBW'(DEB_CYCLES - 1)) begin
                deb_q     <= sync2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + DBW'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        dwell_d     = '0;
        blank_cnt_d = '0;
        advance     = 1'b0;
        case (state_q)
            S_MANUAL: begin
                if (step_pulse) begin
                    advance = 1'b1;
                    state_d = S_BLANK;
                end else begin
                    state_d = auto_mode ? S_AUTO : S_MANUAL;
                end
            end
            S_AUTO: begin
                if (step_pulse || dwell_q == DWW'(DWELL - 1)) begin
                    advance = 1'b1;
                    state_d = S_BLANK;
                end else begin
                    state_d = auto_mode ? S_AUTO : S_MANUAL;
                    dwell_d = auto_mode ? dwell_q + DWW'(1) : '0;
                end
            end
            S_BLANK: begin
                if (blank_cnt_q == BKW'(BLANK_CYC - 1)) begin
                    state_d = auto_mode ? S_AUTO : S_MANUAL;
                end else begin
                    blank_cnt_d = blank_cnt_q + BKW'(1);
                end
            end
            default: state_d = S_MANUAL;
        endcase
        page_d = page_q;
        if (advance) begin
            page_d = (page_q == PW'(PAGES - 1)) ? '0 : page_q + PW'(1);
        end
    end

    always_comb begin
        page_bits = snap_q >> (32'(page_q) * (4 * DIGITS));
        seg_d     = '1;
        if (state_q != S_BLANK) begin
            for (int k = 0; k < DIGITS; k++) begin
                seg_d[7*k +: 7] = seg7(page_bits[4*k +: 4]);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q     <= S_MANUAL;
            page_q      <= '0;
            dwell_q     <= '0;
            blank_cnt_q <= '0;
            snap_q      <= '0;
            seg_q       <= {DIGITS{7'h40}};
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            dwell_q     <= dwell_d;
            blank_cnt_q <= blank_cnt_d;
            seg_q       <= seg_d;
            if (data_valid && !hold) begin
                snap_q <= data_in;
            end
        end
    end

    assign hex_seg  = seg_q;
    assign page_idx = page_q;
    assign blank    = (state_q == S_BLANK);

endmodule

// File: tb/tb_hex_pager.sv
// tb/tb_hex_pager.sv - scoreboard bench for hex_pager with cycle-tagged expectations
module tb_hex_pager;

    localparam logic [55:0] RST_SEG = {8{7'h40}};
    localparam logic [55:0] BLK_SEG = {8{7'h7F}};
    // 0123456789ABCDEF: page 0 = 89ABCDEF, page 1 = 01234567 (digit 7 leftmost)
    localparam logic [55:0] P0_A = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [55:0] P1_A = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    // FEDCBA9876543210: page 0 = 76543210
    localparam logic [55:0] P0_B = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

    logic        clk = 1'b0;
    logic        Reset, data_valid, hold, step_n, auto_mode;
    logic [63:0] data_in;
    logic [55:0] hex_seg;
    logic [0:0]  page_idx;
    logic        blank;

    hex_pager #(
        .DATA_W(64), .DIGITS(8), .DWELL(10), .DEB_CYCLES(4), .BLANK_CYC(2)
    ) dut (
        .CLOCK_50(clk), .Reset(Reset), .data_in(data_in), .data_valid(data_valid),
        .hold(hold), .step_n(step_n), .auto_mode(auto_mode),
        .hex_seg(hex_seg), .page_idx(page_idx), .blank(blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       nm;
        logic        pg;
        logic        bl;
        logic [55:0] sg;
        bit          cs;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int off, input string nm, input logic pg, input logic bl,
                             input logic [55:0] sg, input bit cs);
        exp_t x;
        int   i;
        x.cyc = cyc + off; x.nm = nm; x.pg = pg; x.bl = bl; x.sg = sg; x.cs = cs;
        i = q.size();
        while (i > 0 && q[i-1].cyc > x.cyc) i--;
        q.insert(i, x);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (e.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: due at cycle %0d, reached at %0d", e.nm, e.cyc, cyc);
            end else if (page_idx !== e.pg || blank !== e.bl || (e.cs && hex_seg !== e.sg)) begin
                n_bad++;
                $display("FAIL %s @%0d: got page=%0d blank=%0d seg=%h, want page=%0d blank=%0d seg=%h%s",
                         e.nm, cyc, page_idx, blank, hex_seg, e.pg, e.bl, e.sg, e.cs ? "" : " (seg ignored)");
            end
        end
    end

    task automatic press(input logic pg_old, input logic pg_new, input logic [55:0] seg_new);
        expect_at(5, "pre_step", pg_old, 1'b0, '0, 1'b0);
        step_n = 1'b0;
        expect_at(6, "step_adv", pg_new, 1'b1, '0, 1'b0);
        expect_at(7, "step_blank", pg_new, 1'b1, BLK_SEG, 1'b1);
        expect_at(8, "step_unblank", pg_new, 1'b0, BLK_SEG, 1'b1);
        for (int off = 9; off <= 22; off++) expect_at(off, "step_after", pg_new, 1'b0, seg_new, 1'b1);
        tick(10);
        step_n = 1'b1;
        tick(13);
    endtask

    initial begin
        Reset = 1'b1; data_valid = 1'b0; hold = 1'b0; step_n = 1'b1; auto_mode = 1'b0; data_in = '0;
        tick(2);
        Reset = 1'b0;
        expect_at(0, "reset", 1'b0, 1'b0, RST_SEG, 1'b1);
        tick(1);

        data_valid = 1'b1; data_in = 64'h0123456789ABCDEF;
        expect_at(1, "cap_latency", 1'b0, 1'b0, RST_SEG, 1'b1);
        expect_at(2, "capture", 1'b0, 1'b0, P0_A, 1'b1);
        tick(1);
        data_valid = 1'b0;
        tick(3);

        press(1'b0, 1'b1, P1_A);
        press(1'b1, 1'b0, P0_A);

        for (int off = 0; off <= 30; off++) expect_at(off, "bounce", 1'b0, 1'b0, P0_A, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step_n = (i % 2 == 1);
            tick(2);
        end
        step_n = 1'b1;
        tick(11);

        auto_mode = 1'b1;
        for (int off = 1; off <= 40; off++) begin
            int adv;
            adv = (off >= 11) + (off >= 23) + (off >= 35);
            expect_at(off, "auto", logic'(adv % 2), (off >= 11) && ((off - 11) % 12 < 2), '0, 1'b0);
        end
        tick(40);

        hold = 1'b1; data_valid = 1'b1; data_in = 64'hFEDCBA9876543210;
        expect_at(2, "hold_seg", 1'b1, 1'b0, P1_A, 1'b1);
        expect_at(3, "hold_seg2", 1'b1, 1'b0, P1_A, 1'b1);
        tick(1);
        hold = 1'b0; data_valid = 1'b0;
        tick(5);
        data_valid = 1'b1;
        expect_at(1, "simul_adv", 1'b0, 1'b1, '0, 1'b0);
        expect_at(4, "simul_seg", 1'b0, 1'b0, P0_B, 1'b1);
        tick(1);
        data_valid = 1'b0;
        tick(12);

        expect_at(0, "pre_reset_blank", 1'b1, 1'b1, '0, 1'b0);
        Reset = 1'b1;
        expect_at(1, "reset_mid_blank", 1'b0, 1'b0, RST_SEG, 1'b1);
        tick(1);
        Reset = 1'b0; auto_mode = 1'b0;
        for (int off = 1; off <= 5; off++) expect_at(off, "post_reset", 1'b0, 1'b0, RST_SEG, 1'b1);
        tick(6);

        for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.nm, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
